// File: rtl/rm_report_collector.sv
// Report collector: timestamps each symbol cycle that raises any report bit
// and queues {timestamp, report vector} in a first-word-fall-through FIFO.
module rm_report_collector #(
    parameter int NUM_REPORTS = 28,
    parameter int CNT_W       = 32,
    parameter int DEPTH       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [NUM_REPORTS-1:0]   report_in,
    input  logic                     clear_stats,
    output logic                     rpt_valid,
    input  logic                     rpt_ready,
    output logic [CNT_W-1:0]         rpt_cycle,
    output logic [NUM_REPORTS-1:0]   rpt_vector,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CNT_W-1:0]       sym_cnt;
    logic [CNT_W-1:0]       mem_cycle [DEPTH];
    logic [NUM_REPORTS-1:0] mem_vec   [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   capture;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;

    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    always_comb begin
        capture = run && (|report_in);
        full    = (count == CW'(DEPTH));
        pop     = (count != '0) && rpt_ready;
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_cycle[wr_ptr] <= sym_cnt;
            mem_vec[wr_ptr]   <= report_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (run)
                sym_cnt <= sym_cnt + CNT_W'(1);
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A drop wins over clear_stats, so the stats restart at one drop.
            if (drop) begin
                overflow <= 1'b1;
                if (clear_stats)
                    drop_count <= 16'd1;
                else if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end else if (clear_stats) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

    assign rpt_valid  = (count != '0);
    assign rpt_cycle  = rpt_valid ? mem_cycle[rd_ptr] : '0;
    assign rpt_vector = rpt_valid ? mem_vec[rd_ptr]   : '0;
    assign fifo_count = count;

endmodule

// File: tb/tb_rm_report_collector.sv
// Bench for rm_report_collector: queue-based scoreboard plus a table of
// per-cycle expectations and hand-written corner-case sequences.
module tb_rm_report_collector;

    localparam int NR    = 28;
    localparam int CNT_W = 32;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            run;
    logic [NR-1:0]   report_in;
    logic            clear_stats;
    logic            rpt_valid;
    logic            rpt_ready;
    logic [CNT_W-1:0] rpt_cycle;
    logic [NR-1:0]   rpt_vector;
    logic [3:0]      fifo_count;
    logic            overflow;
    logic [15:0]     drop_count;

    // Second instance with a 4-bit timestamp so the counter wrap is reachable.
    logic            s_reset;
    logic            s_run;
    logic [7:0]      s_report;
    logic            s_clear;
    logic            s_valid;
    logic            s_ready;
    logic [3:0]      s_cycle;
    logic [7:0]      s_vector;
    logic [2:0]      s_count;
    logic            s_ovf;
    logic [15:0]     s_drops;

    always #5 clk = ~clk;

    rm_report_collector #(.NUM_REPORTS(NR), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .run(run), .report_in(report_in),
        .clear_stats(clear_stats), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_cycle(rpt_cycle), .rpt_vector(rpt_vector), .fifo_count(fifo_count),
        .overflow(overflow), .drop_count(drop_count)
    );

    rm_report_collector #(.NUM_REPORTS(8), .CNT_W(4), .DEPTH(4)) dut_small (
        .clk(clk), .reset(s_reset), .run(s_run), .report_in(s_report),
        .clear_stats(s_clear), .rpt_valid(s_valid), .rpt_ready(s_ready),
        .rpt_cycle(s_cycle), .rpt_vector(s_vector), .fifo_count(s_count),
        .overflow(s_ovf), .drop_count(s_drops)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [27:0] vec;
    } ent_t;

    typedef struct {
        logic        run;
        logic [27:0] rep;
        logic        ready;
        logic        clear;
        int          exp_count;
        logic        exp_valid;
        logic        exp_ovf;
        int          exp_drops;
    } vec_t;

    ent_t        exp_q[$];
    logic [31:0] m_sym;
    logic        m_ovf;
    logic [15:0] m_drops;
    int          tests = 0;
    int          fails = 0;
    vec_t        tbl[13];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle, scores the DUT just before the edge, then advances the model.
    task automatic apply_stimulus(input logic r, input logic rn, input logic [27:0] rp,
                                  input logic rd, input logic cl);
        logic pop;
        logic full;
        ent_t e;
        reset = r; run = rn; report_in = rp; rpt_ready = rd; clear_stats = cl;
        @(negedge clk);
        if (r) begin
            exp_q.delete();
            m_sym = '0; m_ovf = 1'b0; m_drops = '0;
        end else begin
            check_output("valid", 64'(rpt_valid), 64'(exp_q.size() != 0));
            check_output("count", 64'(fifo_count), 64'(exp_q.size()));
            check_output("overflow", 64'(overflow), 64'(m_ovf));
            check_output("drop_count", 64'(drop_count), 64'(m_drops));
            if (exp_q.size() != 0) begin
                check_output("head_cycle", 64'(rpt_cycle), 64'(exp_q[0].cyc));
                check_output("head_vector", 64'(rpt_vector), 64'(exp_q[0].vec));
            end else begin
                check_output("empty_cycle", 64'(rpt_cycle), 64'd0);
                check_output("empty_vector", 64'(rpt_vector), 64'd0);
            end
            full = (exp_q.size() == DEPTH);
            pop  = (exp_q.size() != 0) && rd;
            if (pop)
                void'(exp_q.pop_front());
            if (rn && (rp != '0) && (!full || pop)) begin
                e.cyc = m_sym; e.vec = rp;
                exp_q.push_back(e);
            end else if (rn && (rp != '0)) begin
                m_ovf = 1'b1;
                if (cl) m_drops = 16'd1;
                else if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            end else if (cl) begin
                m_ovf = 1'b0; m_drops = '0;
            end
            if (rn) m_sym = m_sym + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    int          s_exp_cyc [4];
    logic [7:0]  s_exp_vec [4];

    initial begin
        // Overflow/clear table: 10 back-to-back captures into an 8-deep FIFO.
        for (int i = 0; i < 10; i++)
            tbl[i] = '{1'b1, 28'(i + 1), 1'b0, 1'b0, (i < 8) ? i + 1 : 8, 1'b1,
                       (i >= 8), (i >= 8) ? i - 7 : 0};
        tbl[10] = '{1'b0, 28'h0,      1'b0, 1'b1, 8, 1'b1, 1'b0, 0};
        tbl[11] = '{1'b1, 28'h0AA,    1'b0, 1'b1, 8, 1'b1, 1'b1, 1};
        tbl[12] = '{1'b1, 28'h0BEEF0, 1'b1, 1'b0, 8, 1'b1, 1'b1, 1};

        s_reset = 1'b1; s_run = 1'b0; s_report = '0; s_ready = 1'b0; s_clear = 1'b0;

        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check_output("reset_valid", 64'(rpt_valid), 64'd0);
        check_output("reset_count", 64'(fifo_count), 64'd0);
        check_output("reset_cycle", 64'(rpt_cycle), 64'd0);
        check_output("reset_vector", 64'(rpt_vector), 64'd0);
        check_output("reset_overflow", 64'(overflow), 64'd0);
        check_output("reset_drops", 64'(drop_count), 64'd0);

        // Single report on the third symbol.
        apply_stimulus(1'b0, 1'b1, 28'h0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 28'h0, 1'b0, 1'b0);
        check_output("single_pre_valid", 64'(rpt_valid), 64'd0);
        apply_stimulus(1'b0, 1'b1, 28'h0000004, 1'b0, 1'b0);
        check_output("single_valid", 64'(rpt_valid), 64'd1);
        check_output("single_cycle", 64'(rpt_cycle), 64'd2);
        check_output("single_vector", 64'(rpt_vector), 64'h4);
        apply_stimulus(1'b0, 1'b1, 28'h0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 28'h0, 1'b0, 1'b0);
        check_output("single_count", 64'(fifo_count), 64'd1);
        drain(2);

        // Overflow, clear_stats, drop-vs-clear and full push+pop.
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(1'b0, tbl[i].run, tbl[i].rep, tbl[i].ready, tbl[i].clear);
            check_output($sformatf("tbl%0d_count", i), 64'(fifo_count), 64'(tbl[i].exp_count));
            check_output($sformatf("tbl%0d_valid", i), 64'(rpt_valid), 64'(tbl[i].exp_valid));
            check_output($sformatf("tbl%0d_ovf", i), 64'(overflow), 64'(tbl[i].exp_ovf));
            check_output($sformatf("tbl%0d_drops", i), 64'(drop_count), 64'(tbl[i].exp_drops));
        end
        check_output("full_head_cycle", 64'(rpt_cycle), 64'd1);
        drain(7);
        check_output("last_out_cycle", 64'(rpt_cycle), 64'd11);
        check_output("last_out_vector", 64'(rpt_vector), 64'h0BEEF0);
        drain(2);

        // report_in with run low is ignored and does not advance the timestamp.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b0, 28'hFFFFFFF, 1'b0, 1'b0);
            check_output("ignored_count", 64'(fifo_count), 64'd0);
        end
        apply_stimulus(1'b0, 1'b1, 28'h1, 1'b0, 1'b0);
        check_output("gap_cycle", 64'(rpt_cycle), 64'd12);
        drain(2);

        // Reset during a pop with a simultaneous capture discards everything.
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b0, 1'b1, 28'(i + 16), 1'b0, 1'b0);
        check_output("pre_reset_count", 64'(fifo_count), 64'd4);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 28'h5, 1'b1, 1'b0);
        check_output("midreset_valid", 64'(rpt_valid), 64'd0);
        check_output("midreset_count", 64'(fifo_count), 64'd0);
        apply_stimulus(1'b0, 1'b1, 28'h9, 1'b0, 1'b0);
        check_output("post_reset_cycle", 64'(rpt_cycle), 64'd0);
        check_output("post_reset_vector", 64'(rpt_vector), 64'h9);
        drain(2);

        // Timestamp wrap on the 4-bit instance: reports on symbols 14, 15, 0, 1.
        s_exp_cyc = '{14, 15, 0, 1};
        s_exp_vec = '{8'h01, 8'h02, 8'h04, 8'h08};
        s_reset = 1'b1;
        @(posedge clk); #1;
        s_reset = 1'b0; s_run = 1'b1; s_report = '0;
        repeat (14) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++) begin
            s_report = s_exp_vec[i];
            @(posedge clk); #1;
        end
        s_run = 1'b0; s_report = '0;
        check_output("wrap_count", 64'(s_count), 64'd4);
        s_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output($sformatf("wrap%0d_cycle", i), 64'(s_cycle), 64'(s_exp_cyc[i]));
            check_output($sformatf("wrap%0d_vector", i), 64'(s_vector), 64'(s_exp_vec[i]));
            @(posedge clk); #1;
        end
        check_output("wrap_empty", 64'(s_valid), 64'd0);
        s_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
